// File: rtl/motor_controller_core_pio_pkg.sv
// Shared definitions for the motor_controller_core parallel I/O blocks:
// register word addresses, edge-capture encodings and small helpers.
package motor_controller_core_pio_pkg;

    localparam int BUS_W = 32;

    localparam logic [1:0] ADDR_DATA     = 2'd0;
    localparam logic [1:0] ADDR_RESERVED = 2'd1;
    localparam logic [1:0] ADDR_IRQMASK  = 2'd2;
    localparam logic [1:0] ADDR_EDGECAP  = 2'd3;

    localparam int EDGE_RISING  = 0;
    localparam int EDGE_FALLING = 1;
    localparam int EDGE_ANY     = 2;

    // Width of a counter that must hold values up to 'cycles'; never below one bit.
    function automatic int cnt_width(input int cycles);
        return (cycles < 1) ? 1 : $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/motor_controller_core_switch_in_debounce.sv
// One input line: two-flop synchroniser followed by a stability filter.
// The filtered output only follows the synchronised value once it has
// differed from it for DEBOUNCE_CYCLES consecutive clocks; 0 bypasses the filter.
module motor_controller_core_switch_in_debounce
    import motor_controller_core_pio_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000
) (
    input  logic clk,
    input  logic reset,
    input  logic pin,
    output logic filtered
);

    logic sync_p0;
    logic sync_p1;

    // Bring the asynchronous pin into the clk domain.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
        end else begin
            sync_p0 <= pin;
            sync_p1 <= sync_p0;
        end
    end

    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_bypass
            assign filtered = sync_p1;
        end else begin : g_filter
            localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES);
            localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

            logic [CNT_W-1:0] cnt_p2;
            logic             filt_p2;

            // Count consecutive clocks of disagreement; any agreement restarts the count.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    cnt_p2  <= '0;
                    filt_p2 <= 1'b0;
                end else if (sync_p1 == filt_p2) begin
                    cnt_p2 <= '0;
                end else if (cnt_p2 >= CNT_LAST) begin
                    filt_p2 <= sync_p1;
                    cnt_p2  <= '0;
                end else begin
                    cnt_p2 <= cnt_p2 + 1'b1;
                end
            end

            assign filtered = filt_p2;
        end
    endgenerate

endmodule

// File: rtl/motor_controller_core_switch_in.sv
// Avalon-MM switch/sensor input port: debounced DATA, maskable edge capture
// and a registered level interrupt. Zero-wait-state reads and writes.
module motor_controller_core_switch_in
    import motor_controller_core_pio_pkg::*;
#(
    parameter int WIDTH           = 8,
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int EDGE_TYPE       = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    logic [WIDTH-1:0] filtered;
    logic [WIDTH-1:0] prev;
    logic [WIDTH-1:0] irqmask;
    logic [WIDTH-1:0] edgecap;
    logic [WIDTH-1:0] detected;
    logic [WIDTH-1:0] clear;
    logic             wr_en;
    logic             unused_wdata;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        motor_controller_core_switch_in_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk     (clk),
            .reset   (reset),
            .pin     (in_port[i]),
            .filtered(filtered[i])
        );
    end

    assign wr_en        = chipselect & ~write_n;
    assign unused_wdata = ^writedata;

    // Select which filtered transitions count as an edge, and decode clear-writes.
    always_comb begin
        detected = filtered & ~prev;
        if (EDGE_TYPE == EDGE_FALLING) begin
            detected = ~filtered & prev;
        end else if (EDGE_TYPE == EDGE_ANY) begin
            detected = filtered ^ prev;
        end
        clear = '0;
        if (wr_en && (address == ADDR_EDGECAP)) begin
            clear = writedata[WIDTH-1:0];
        end
    end

    // Register file, edge history and interrupt; a new edge beats a same-cycle clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev    <= '0;
            irqmask <= '0;
            edgecap <= '0;
            irq     <= 1'b0;
        end else begin
            prev    <= filtered;
            edgecap <= (edgecap & ~clear) | detected;
            irq     <= |(edgecap & irqmask);
            if (wr_en && (address == ADDR_IRQMASK)) begin
                irqmask <= writedata[WIDTH-1:0];
            end
        end
    end

    // Combinational read mux, zero-extended to the bus width.
    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA:    readdata = 32'(filtered);
            ADDR_IRQMASK: readdata = 32'(irqmask);
            ADDR_EDGECAP: readdata = 32'(edgecap);
            default:      readdata = '0;
        endcase
    end

endmodule

// File: tb/tb_motor_controller_core_switch_in.sv
// Testbench for motor_controller_core_switch_in: a filtered rising-edge
// instance (DEBOUNCE_CYCLES=4) and a bypass any-edge instance share one bus.
module tb_motor_controller_core_switch_in;
    import motor_controller_core_pio_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata_a;
    logic [31:0] readdata_b;
    logic        irq_a;
    logic        irq_b;
    logic [7:0]  in_a;
    logic [7:0]  in_b;

    int          pass_cnt  = 0;
    int          total_cnt = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp;
    logic [1:0]  addrs[3] = '{ADDR_DATA, ADDR_IRQMASK, ADDR_EDGECAP};

    always #5 clk = ~clk;

    motor_controller_core_switch_in #(
        .WIDTH(8), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(EDGE_RISING)
    ) dut_a (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(readdata_a),
        .in_port(in_a), .irq(irq_a)
    );

    motor_controller_core_switch_in #(
        .WIDTH(8), .DEBOUNCE_CYCLES(0), .EDGE_TYPE(EDGE_ANY)
    ) dut_b (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(readdata_b),
        .in_port(in_b), .irq(irq_b)
    );

    // Called at a negedge; the write lands on the following posedge and the
    // task returns on the negedge after it.
    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
    endtask

    task automatic set_addr(input logic [1:0] a);
        address = a;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        in_a  = 8'hFF;
        in_b  = 8'h00;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            exp_q.push_back(32'h0);
            set_addr(addrs[k]);
            exp = exp_q.pop_front();
            total_cnt++;
            if (readdata_a !== exp) $display("FAIL reset_read_addr%0d: got %h want %h", addrs[k], readdata_a, exp);
            else pass_cnt++;
        end
        exp_q.push_back(32'h0);
        exp = exp_q.pop_front();
        total_cnt++;
        if (32'(irq_a) !== exp) $display("FAIL reset_irq: got %0d want %0d", irq_a, exp);
        else pass_cnt++;
        in_a = 8'h00;
        @(negedge clk);
        reset = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic test_debounce();
        in_a[0] = 1'b1;
        exp_q.push_back(32'h00);
        exp_q.push_back(32'h01);
        repeat (5) @(negedge clk);
        set_addr(ADDR_DATA);
        exp = exp_q.pop_front();
        total_cnt++;
        if (readdata_a !== exp) $display("FAIL data_before_latency: got %h want %h", readdata_a, exp);
        else pass_cnt++;
        @(negedge clk);
        exp = exp_q.pop_front();
        total_cnt++;
        if (readdata_a !== exp) $display("FAIL data_at_latency: got %h want %h", readdata_a, exp);
        else pass_cnt++;
        // 3-clock glitch on bit 1 must be swallowed
        in_a[1] = 1'b1;
        repeat (3) @(negedge clk);
        in_a[1] = 1'b0;
        for (int k = 0; k < 8; k++) begin
            exp_q.push_back(32'h01);
            @(negedge clk);
            exp = exp_q.pop_front();
            total_cnt++;
            if (readdata_a !== exp) $display("FAIL glitch_rejected_cyc%0d: got %h want %h", k, readdata_a, exp);
            else pass_cnt++;
        end
        exp_q.push_back(32'h01);
        set_addr(ADDR_EDGECAP);
        exp = exp_q.pop_front();
        total_cnt++;
        if (readdata_a !== exp) $display("FAIL edgecap_after_debounce: got %h want %h", readdata_a, exp);
        else pass_cnt++;
    endtask

    task automatic test_rise_irq();
        @(negedge clk);
        bus_write(ADDR_EDGECAP, 32'hFF);
        in_a[0] = 1'b0;
        exp_q.push_back(32'h00);
        repeat (8) @(negedge clk);
        set_addr(ADDR_EDGECAP);
        exp = exp_q.pop_front();
        total_cnt++;
        if (readdata_a !== exp) $display("FAIL falling_not_captured: got %h want %h", readdata_a, exp);
        else pass_cnt++;
        @(negedge clk);
        bus_write(ADDR_RESERVED, 32'hFFFF_FFFF);
        exp_q.push_back(32'h0);
        set_addr(ADDR_RESERVED);
        exp = exp_q.pop_front();
        total_cnt++;
        if (readdata_a !== exp) $display("FAIL reserved_reads_zero: got %h want %h", readdata_a, exp);
        else pass_cnt++;
        @(negedge clk);
        bus_write(ADDR_IRQMASK, 32'h01);
        in_a[0] = 1'b1;
        exp_q.push_back(32'h01);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h1);
        repeat (7) @(negedge clk);
        set_addr(ADDR_EDGECAP);
        exp = exp_q.pop_front();
        total_cnt++;
        if (readdata_a !== exp) $display("FAIL rise_captured: got %h want %h", readdata_a, exp);
        else pass_cnt++;
        exp = exp_q.pop_front();
        total_cnt++;
        if (32'(irq_a) !== exp) $display("FAIL irq_not_yet: got %0d want %0d", irq_a, exp);
        else pass_cnt++;
        @(negedge clk);
        exp = exp_q.pop_front();
        total_cnt++;
        if (32'(irq_a) !== exp) $display("FAIL irq_asserted: got %0d want %0d", irq_a, exp);
        else pass_cnt++;
        bus_write(ADDR_EDGECAP, 32'h01);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h0);
        set_addr(ADDR_EDGECAP);
        exp = exp_q.pop_front();
        total_cnt++;
        if (readdata_a !== exp) $display("FAIL edgecap_cleared: got %h want %h", readdata_a, exp);
        else pass_cnt++;
        @(negedge clk);
        exp = exp_q.pop_front();
        total_cnt++;
        if (32'(irq_a) !== exp) $display("FAIL irq_deasserted: got %0d want %0d", irq_a, exp);
        else pass_cnt++;
    endtask

    task automatic test_clear_race();
        bus_write(ADDR_IRQMASK, 32'h00);
        in_a[2] = 1'b1;
        exp_q.push_back(32'h04);
        repeat (8) @(negedge clk);
        set_addr(ADDR_EDGECAP);
        exp = exp_q.pop_front();
        total_cnt++;
        if (readdata_a !== exp) $display("FAIL bit2_first_edge: got %h want %h", readdata_a, exp);
        else pass_cnt++;
        in_a[2] = 1'b0;
        repeat (8) @(negedge clk);
        in_a[2] = 1'b1;
        exp_q.push_back(32'h04);
        exp_q.push_back(32'h00);
        repeat (6) @(negedge clk);
        bus_write(ADDR_EDGECAP, 32'h04);
        set_addr(ADDR_EDGECAP);
        exp = exp_q.pop_front();
        total_cnt++;
        if (readdata_a !== exp) $display("FAIL clear_race_edge_wins: got %h want %h", readdata_a, exp);
        else pass_cnt++;
        @(negedge clk);
        bus_write(ADDR_EDGECAP, 32'h04);
        set_addr(ADDR_EDGECAP);
        exp = exp_q.pop_front();
        total_cnt++;
        if (readdata_a !== exp) $display("FAIL plain_clear: got %h want %h", readdata_a, exp);
        else pass_cnt++;
    endtask

    task automatic test_mask_partial();
        @(negedge clk);
        bus_write(ADDR_IRQMASK, 32'hFFFF_FF02);
        exp_q.push_back(32'h02);
        set_addr(ADDR_IRQMASK);
        exp = exp_q.pop_front();
        total_cnt++;
        if (readdata_a !== exp) $display("FAIL irqmask_upper_ignored: got %h want %h", readdata_a, exp);
        else pass_cnt++;
        in_a[1] = 1'b1;
        in_a[3] = 1'b1;
        exp_q.push_back(32'h0A);
        exp_q.push_back(32'h1);
        repeat (10) @(negedge clk);
        set_addr(ADDR_EDGECAP);
        exp = exp_q.pop_front();
        total_cnt++;
        if (readdata_a !== exp) $display("FAIL edges_bits_1_3: got %h want %h", readdata_a, exp);
        else pass_cnt++;
        exp = exp_q.pop_front();
        total_cnt++;
        if (32'(irq_a) !== exp) $display("FAIL irq_masked_bit1: got %0d want %0d", irq_a, exp);
        else pass_cnt++;
        @(negedge clk);
        bus_write(ADDR_EDGECAP, 32'h02);
        exp_q.push_back(32'h08);
        exp_q.push_back(32'h0);
        @(negedge clk);
        set_addr(ADDR_EDGECAP);
        exp = exp_q.pop_front();
        total_cnt++;
        if (readdata_a !== exp) $display("FAIL partial_clear: got %h want %h", readdata_a, exp);
        else pass_cnt++;
        exp = exp_q.pop_front();
        total_cnt++;
        if (32'(irq_a) !== exp) $display("FAIL irq_after_partial_clear: got %0d want %0d", irq_a, exp);
        else pass_cnt++;
        @(negedge clk);
        bus_write(ADDR_IRQMASK, 32'h08);
        exp_q.push_back(32'h1);
        @(negedge clk);
        exp = exp_q.pop_front();
        total_cnt++;
        if (32'(irq_a) !== exp) $display("FAIL irq_after_mask_bit3: got %0d want %0d", irq_a, exp);
        else pass_cnt++;
    endtask

    task automatic test_any_edge_bypass_reset();
        in_b[5] = 1'b1;
        exp_q.push_back(32'h20);
        exp_q.push_back(32'h00);
        exp_q.push_back(32'h20);
        repeat (2) @(negedge clk);
        set_addr(ADDR_DATA);
        exp = exp_q.pop_front();
        total_cnt++;
        if (readdata_b !== exp) $display("FAIL bypass_data_2clk: got %h want %h", readdata_b, exp);
        else pass_cnt++;
        set_addr(ADDR_EDGECAP);
        exp = exp_q.pop_front();
        total_cnt++;
        if (readdata_b !== exp) $display("FAIL any_rise_not_yet: got %h want %h", readdata_b, exp);
        else pass_cnt++;
        @(negedge clk);
        exp = exp_q.pop_front();
        total_cnt++;
        if (readdata_b !== exp) $display("FAIL any_rise_captured: got %h want %h", readdata_b, exp);
        else pass_cnt++;
        bus_write(ADDR_EDGECAP, 32'h20);
        in_b[5] = 1'b0;
        exp_q.push_back(32'h00);
        exp_q.push_back(32'h20);
        repeat (3) @(negedge clk);
        set_addr(ADDR_DATA);
        exp = exp_q.pop_front();
        total_cnt++;
        if (readdata_b !== exp) $display("FAIL bypass_data_fall: got %h want %h", readdata_b, exp);
        else pass_cnt++;
        set_addr(ADDR_EDGECAP);
        exp = exp_q.pop_front();
        total_cnt++;
        if (readdata_b !== exp) $display("FAIL any_fall_captured: got %h want %h", readdata_b, exp);
        else pass_cnt++;
        // reset while dut_a is mid-debounce on bit 6 and holding a pending irq
        @(negedge clk);
        in_a[6] = 1'b1;
        exp_q.push_back(32'h1);
        repeat (3) @(negedge clk);
        exp = exp_q.pop_front();
        total_cnt++;
        if (32'(irq_a) !== exp) $display("FAIL irq_pending_before_reset: got %0d want %0d", irq_a, exp);
        else pass_cnt++;
        #2;
        reset = 1'b1;
        #1;
        exp_q.push_back(32'h0);
        exp = exp_q.pop_front();
        total_cnt++;
        if (32'(irq_a) !== exp) $display("FAIL irq_cleared_by_reset: got %0d want %0d", irq_a, exp);
        else pass_cnt++;
        for (int k = 0; k < 3; k++) begin
            exp_q.push_back(32'h0);
            set_addr(addrs[k]);
            exp = exp_q.pop_front();
            total_cnt++;
            if ((readdata_a | readdata_b) !== exp) $display("FAIL midreset_read_addr%0d: got %h/%h want %h", addrs[k], readdata_a, readdata_b, exp);
            else pass_cnt++;
        end
        in_a = 8'h00;
        in_b = 8'h00;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h0);
        repeat (10) @(negedge clk);
        set_addr(ADDR_EDGECAP);
        exp = exp_q.pop_front();
        total_cnt++;
        if ((readdata_a | readdata_b) !== exp) $display("FAIL no_edge_from_reset: got %h/%h want %h", readdata_a, readdata_b, exp);
        else pass_cnt++;
        exp = exp_q.pop_front();
        total_cnt++;
        if (32'(irq_a | irq_b) !== exp) $display("FAIL irq_after_reset: got %0d/%0d want %0d", irq_a, irq_b, exp);
        else pass_cnt++;
    endtask

    initial begin
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        test_reset();
        test_debounce();
        test_rise_irq();
        test_clear_race();
        test_mask_partial();
        test_any_edge_bypass_reset();
        if (exp_q.size() != 0) begin
            total_cnt++;
            $display("FAIL scoreboard_leftover: got %0d entries want 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
